dataslot_cmd_responder: RTL and testbench

- Host-side responder for the target dataslot command interface that the high-score save logic initiates.
- Holds one slot's contents in an internal byte store.
- On a read command it pushes slot bytes into the core over bridge word writes. On a write command it pulls bytes out of the core over bridge word reads.
- Used as the APF host stand-in for core-level benches and for the BRAM-backed save fallback. Sits on clk_74a between the initiator and the bytewise bridge decoders.

---
 rtl/dataslot_cmd_responder_if.sv | 52 +++++
 rtl/dataslot_cmd_responder.sv | 210 +++++++++++++++++++++
 tb/tb_dataslot_cmd_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dataslot_cmd_responder_if.sv
// Command and bridge signals between the dataslot initiator, this responder and the core bridge.
// The responder connects through the slave modport; the initiator side uses master.
interface dataslot_cmd_responder_if;
  logic        target_dataslot_read;
  logic        target_dataslot_write;
  logic [15:0] target_dataslot_id;
  logic [31:0] target_dataslot_slotoffset;
  logic [31:0] target_dataslot_bridgeaddr;
  logic [31:0] target_dataslot_length;
  logic        target_dataslot_ack;
  logic        target_dataslot_done;
  logic        target_dataslot_err;
  logic [31:0] bridge_addr;
  logic [31:0] bridge_wr_data;
  logic        bridge_wr;
  logic        bridge_rd;
  logic [31:0] bridge_rd_data;

  modport slave (
    input  target_dataslot_read,
    input  target_dataslot_write,
    input  target_dataslot_id,
    input  target_dataslot_slotoffset,
    input  target_dataslot_bridgeaddr,
    input  target_dataslot_length,
    output target_dataslot_ack,
    output target_dataslot_done,
    output target_dataslot_err,
    output bridge_addr,
    output bridge_wr_data,
    output bridge_wr,
    output bridge_rd,
    input  bridge_rd_data
  );

  modport master (
    output target_dataslot_read,
    output target_dataslot_write,
    output target_dataslot_id,
    output target_dataslot_slotoffset,
    output target_dataslot_bridgeaddr,
    output target_dataslot_length,
    input  target_dataslot_ack,
    input  target_dataslot_done,
    input  target_dataslot_err,
    input  bridge_addr,
    input  bridge_wr_data,
    input  bridge_wr,
    input  bridge_rd,
    output bridge_rd_data
  );
endinterface

// File: rtl/dataslot_cmd_responder.sv
// Host-side dataslot responder: serves one slot from a byte store, pushing it into the core
// with bridge word writes (read command) or pulling it back with bridge word reads (write command).
module dataslot_cmd_responder #(
  parameter logic [15:0] SLOT_ID    = 16'd2,
  parameter int unsigned SLOT_BYTES = 128,
  parameter int unsigned RD_LATENCY = 16,
  parameter int unsigned WR_GAP     = 8
) (
  input  logic                           clk_74a,
  input  logic                           reset,
  dataslot_cmd_responder_if.slave        bus,
  input  logic [11:0]                    store_addr_i,
  input  logic                           store_wr_i,
  input  logic [7:0]                     store_wdata_i,
  output logic [7:0]                     store_q_o
);

  localparam int unsigned AddrW = $clog2(SLOT_BYTES);

  typedef enum logic [2:0] {
    StIdle, StCheck, StPush, StPushGap, StPullIssue, StPullWait, StComplete
  } state_e;

  state_e      state_q, state_d;
  logic        rd_req_q, wr_req_q;
  logic        cmd_rd_q, cmd_rd_d, cmd_wr_q, cmd_wr_d;
  logic [15:0] id_q, id_d;
  logic [31:0] off_q, off_d, base_q, base_d, len_q, len_d, pos_q, pos_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic [31:0] baddr_q, baddr_d, bwdata_q, bwdata_d;
  logic        bwr_q, bwr_d, brd_q, brd_d;

  logic [7:0]       mem_q [SLOT_BYTES];
  logic [AddrW-1:0] side_addr;
  logic [AddrW-1:0] byte_addr [4];
  logic [3:0]       byte_ok;
  logic [3:0]       eng_we;
  logic [31:0]      push_word;
  logic             rd_rise, wr_rise, range_err, last_word;
  logic [32:0]      range_sum;

  assign side_addr = store_addr_i[AddrW-1:0];

  if (AddrW < 12) begin : g_addr_unused
    logic unused_addr_hi;
    assign unused_addr_hi = ^store_addr_i[11:AddrW];
  end

  assign rd_rise   = bus.target_dataslot_read & ~rd_req_q;
  assign wr_rise   = bus.target_dataslot_write & ~wr_req_q;
  assign range_sum = {1'b0, off_q} + {1'b0, len_q};
  assign range_err = range_sum > 33'(SLOT_BYTES);
  assign last_word = (pos_q + 32'd4) >= len_q;

  // Byte +0 of each word sits in bits [31:24]; bytes at or past length are masked.
  always_comb begin
    push_word = '0;
    eng_we    = '0;
    for (int j = 0; j < 4; j++) begin
      byte_addr[j] = AddrW'(off_q + pos_q + 32'(j));
      byte_ok[j]   = (pos_q + 32'(j)) < len_q;
      if (byte_ok[j]) push_word[31-8*j -: 8] = mem_q[byte_addr[j]];
      eng_we[j] = (state_q == StPullWait) && (cnt_q == '0) && byte_ok[j];
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_rd_d = cmd_rd_q;
    cmd_wr_d = cmd_wr_q;
    id_d     = id_q;
    off_d    = off_q;
    base_d   = base_q;
    len_d    = len_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    done_d   = 1'b0;
    err_d    = err_q;
    baddr_d  = baddr_q;
    bwdata_d = bwdata_q;
    bwr_d    = 1'b0;
    brd_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (rd_rise || wr_rise) begin
          cmd_rd_d = rd_rise;
          cmd_wr_d = wr_rise;
          id_d     = bus.target_dataslot_id;
          off_d    = bus.target_dataslot_slotoffset;
          base_d   = bus.target_dataslot_bridgeaddr;
          len_d    = bus.target_dataslot_length;
          pos_d    = '0;
          ack_d    = 1'b1;
          err_d    = 1'b0;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if ((id_q != SLOT_ID) || range_err || (cmd_rd_q && cmd_wr_q)) begin
          err_d   = 1'b1;
          state_d = StComplete;
        end else if (len_q == '0) begin
          state_d = StComplete;
        end else if (cmd_rd_q) begin
          state_d = StPush;
        end else begin
          state_d = StPullIssue;
        end
      end
      StPush: begin
        bwr_d    = 1'b1;
        baddr_d  = base_q + pos_q;
        bwdata_d = push_word;
        cnt_d    = 16'(WR_GAP - 1);
        state_d  = StPushGap;
      end
      StPushGap: begin
        if (cnt_q == '0) begin
          pos_d   = pos_q + 32'd4;
          state_d = last_word ? StComplete : StPush;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StPullIssue: begin
        brd_d   = 1'b1;
        baddr_d = base_q + pos_q;
        cnt_d   = 16'(RD_LATENCY);
        state_d = StPullWait;
      end
      StPullWait: begin
        // The store write for this word happens in the cnt == 0 cycle via eng_we.
        if (cnt_q == '0) begin
          pos_d   = pos_q + 32'd4;
          state_d = last_word ? StComplete : StPullIssue;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StComplete: begin
        ack_d   = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      cmd_rd_q <= 1'b0;
      cmd_wr_q <= 1'b0;
      id_q     <= '0;
      off_q    <= '0;
      base_q   <= '0;
      len_q    <= '0;
      pos_q    <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      baddr_q  <= '0;
      bwdata_q <= '0;
      bwr_q    <= 1'b0;
      brd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_req_q <= bus.target_dataslot_read;
      wr_req_q <= bus.target_dataslot_write;
      cmd_rd_q <= cmd_rd_d;
      cmd_wr_q <= cmd_wr_d;
      id_q     <= id_d;
      off_q    <= off_d;
      base_q   <= base_d;
      len_q    <= len_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      baddr_q  <= baddr_d;
      bwdata_q <= bwdata_d;
      bwr_q    <= bwr_d;
      brd_q    <= brd_d;
    end
  end

  // Engine writes are issued after the side write so the engine wins a same-byte collision.
  always_ff @(posedge clk_74a) begin
    if (store_wr_i) mem_q[side_addr] <= store_wdata_i;
    for (int j = 0; j < 4; j++) begin
      if (eng_we[j]) mem_q[byte_addr[j]] <= bus.bridge_rd_data[31-8*j -: 8];
    end
    store_q_o <= mem_q[side_addr];
  end

  assign bus.target_dataslot_ack  = ack_q;
  assign bus.target_dataslot_done = done_q;
  assign bus.target_dataslot_err  = err_q;
  assign bus.bridge_addr          = baddr_q;
  assign bus.bridge_wr_data       = bwdata_q;
  assign bus.bridge_wr            = bwr_q;
  assign bus.bridge_rd            = brd_q;

endmodule

// File: tb/tb_dataslot_cmd_responder.sv
// Directed bench for dataslot_cmd_responder: push, pull, error paths, ignored edges, mid-command reset.
module tb_dataslot_cmd_responder;
  localparam int RdLat = 16;
  localparam int WrGap = 8;

  logic        clk_74a = 1'b0;
  logic        reset   = 1'b1;
  logic [11:0] store_addr = '0;
  logic        store_wr   = 1'b0;
  logic [7:0]  store_wdata = '0;
  logic [7:0]  store_q;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_74a = ~clk_74a;

  dataslot_cmd_responder_if dif ();

  dataslot_cmd_responder #(
    .SLOT_ID   (16'd2),
    .SLOT_BYTES(128),
    .RD_LATENCY(RdLat),
    .WR_GAP    (WrGap)
  ) dut (
    .clk_74a      (clk_74a),
    .reset        (reset),
    .bus          (dif),
    .store_addr_i (store_addr),
    .store_wr_i   (store_wr),
    .store_wdata_i(store_wdata),
    .store_q_o    (store_q)
  );

  // Bridge-side monitor and read responder; rd data is valid only in the RdLat sample cycle.
  int          cyc = 0;
  int          wr_n = 0, rd_n = 0, ack_total = 0, done_total = 0;
  int          rd_cyc = -1000;
  int          rd_start = 0;
  logic [7:0]  rd_base = 8'hA0;
  logic [31:0] rd_word = '0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_cyc  [64];

  function automatic logic [31:0] rep4(input logic [7:0] b);
    return {b, b, b, b};
  endfunction

  always @(posedge clk_74a) cyc <= cyc + 1;

  always @(negedge clk_74a) begin
    ack_total  <= ack_total + int'(dif.target_dataslot_ack);
    done_total <= done_total + int'(dif.target_dataslot_done);
    if (dif.bridge_wr) begin
      wr_addr[wr_n & 63] <= dif.bridge_addr;
      wr_data[wr_n & 63] <= dif.bridge_wr_data;
      wr_cyc[wr_n & 63]  <= cyc;
      wr_n <= wr_n + 1;
    end
    if (dif.bridge_rd) begin
      rd_cyc  <= cyc;
      rd_word <= rep4(rd_base + 8'(rd_n - rd_start));
      rd_n    <= rd_n + 1;
    end
    if (cyc == rd_cyc + RdLat) dif.bridge_rd_data <= rd_word;
    else dif.bridge_rd_data <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input bit rd, input bit wr, input logic [15:0] id,
                         input logic [31:0] off, input logic [31:0] len, input logic [31:0] base,
                         output logic ack1, output logic got_err, output logic got_done,
                         output logic ack_at_done);
    dif.target_dataslot_id         = id;
    dif.target_dataslot_slotoffset = off;
    dif.target_dataslot_length     = len;
    dif.target_dataslot_bridgeaddr = base;
    @(negedge clk_74a);
    dif.target_dataslot_read  = rd;
    dif.target_dataslot_write = wr;
    ack1 = 1'b0; got_err = 1'b0; got_done = 1'b0; ack_at_done = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_74a);
      if (i == 0) ack1 = dif.target_dataslot_ack;
      if (i == 1) begin
        dif.target_dataslot_read  = 1'b0;
        dif.target_dataslot_write = 1'b0;
      end
      if (dif.target_dataslot_done) begin
        got_done    = 1'b1;
        got_err     = dif.target_dataslot_err;
        ack_at_done = dif.target_dataslot_ack;
        break;
      end
    end
    repeat (3) @(negedge clk_74a);
  endtask

  task automatic side_rd(input logic [11:0] a, output logic [7:0] q);
    @(negedge clk_74a);
    store_addr = a;
    @(negedge clk_74a);
    q = store_q;
  endtask

  initial begin
    logic       a1, e, d, ad;
    logic [7:0] q;
    int         s_wr, s_rd, s_ack, s_done;

    dif.target_dataslot_read       = 1'b0;
    dif.target_dataslot_write      = 1'b0;
    dif.target_dataslot_id         = '0;
    dif.target_dataslot_slotoffset = '0;
    dif.target_dataslot_length     = '0;
    dif.target_dataslot_bridgeaddr = '0;

    repeat (3) @(negedge clk_74a);
    chk("rst_ack", 32'(dif.target_dataslot_ack), 0);
    chk("rst_done", 32'(dif.target_dataslot_done), 0);
    chk("rst_err", 32'(dif.target_dataslot_err), 0);
    chk("rst_wr_rd", {30'd0, dif.bridge_wr, dif.bridge_rd}, 0);
    chk("rst_addr", dif.bridge_addr, 0);
    chk("rst_wdata", dif.bridge_wr_data, 0);
    reset = 1'b0;

    // Seed bytes 0..82 with their index, byte 83 with a marker
    for (int i = 0; i < 84; i++) begin
      @(negedge clk_74a);
      store_addr  = 12'(i);
      store_wdata = (i == 83) ? 8'h5A : 8'(i);
      store_wr    = 1'b1;
    end
    @(negedge clk_74a);
    store_wr = 1'b0;
    side_rd(12'd5, q);
    chk("side_rd5", 32'(q), 32'h05);

    // Read command: push 83 bytes as 21 words
    s_wr = wr_n; s_done = done_total;
    run_cmd(1, 0, 16'd2, 0, 83, 32'h1000_0000, a1, e, d, ad);
    chk("push_ack1", 32'(a1), 1);
    chk("push_done", 32'(d), 1);
    chk("push_err", 32'(e), 0);
    chk("push_ack_at_done", 32'(ad), 0);
    chk("push_count", 32'(wr_n - s_wr), 21);
    chk("push_w0_data", wr_data[s_wr & 63], 32'h0001_0203);
    chk("push_w0_addr", wr_addr[s_wr & 63], 32'h1000_0000);
    chk("push_w10_data", wr_data[(s_wr + 10) & 63], 32'h2829_2A2B);
    chk("push_w20_data", wr_data[(s_wr + 20) & 63], 32'h5051_5200);
    chk("push_w20_addr", wr_addr[(s_wr + 20) & 63], 32'h1000_0050);
    chk("push_spacing", 32'(wr_cyc[(s_wr + 1) & 63] - wr_cyc[s_wr & 63]), 32'(WrGap + 1));
    chk("push_done_cnt", 32'(done_total - s_done), 1);

    // Write command: pull 21 words of 0xA0+k
    rd_base = 8'hA0; rd_start = rd_n; s_rd = rd_n;
    run_cmd(0, 1, 16'd2, 0, 83, 32'h2000_0000, a1, e, d, ad);
    chk("pull_done", 32'(d), 1);
    chk("pull_err", 32'(e), 0);
    chk("pull_count", 32'(rd_n - s_rd), 21);
    side_rd(12'd0, q);  chk("pull_b0", 32'(q), 32'hA0);
    side_rd(12'd3, q);  chk("pull_b3", 32'(q), 32'hA0);
    side_rd(12'd4, q);  chk("pull_b4", 32'(q), 32'hA1);
    side_rd(12'd80, q); chk("pull_b80", 32'(q), 32'hB4);
    side_rd(12'd82, q); chk("pull_b82", 32'(q), 32'hB4);
    side_rd(12'd83, q); chk("pull_b83", 32'(q), 32'h5A);

    // Wrong slot id
    s_wr = wr_n; s_rd = rd_n; s_ack = ack_total;
    run_cmd(1, 0, 16'd3, 0, 16, 32'h0, a1, e, d, ad);
    chk("badid_done", 32'(d), 1);
    chk("badid_err", 32'(e), 1);
    chk("badid_strobes", 32'((wr_n - s_wr) + (rd_n - s_rd)), 0);
    chk("badid_ack_cycles", 32'(ack_total - s_ack), 2);

    // Out of range: 100 + 40 > 128
    s_wr = wr_n; s_rd = rd_n; s_ack = ack_total;
    run_cmd(0, 1, 16'd2, 100, 40, 32'h0, a1, e, d, ad);
    chk("range_err", 32'(e), 1);
    chk("range_strobes", 32'((wr_n - s_wr) + (rd_n - s_rd)), 0);
    chk("range_ack_cycles", 32'(ack_total - s_ack), 2);

    // Zero length
    s_wr = wr_n; s_rd = rd_n;
    run_cmd(1, 0, 16'd2, 0, 0, 32'h0, a1, e, d, ad);
    chk("len0_done", 32'(d), 1);
    chk("len0_err", 32'(e), 0);
    chk("len0_strobes", 32'((wr_n - s_wr) + (rd_n - s_rd)), 0);

    // Read and write rising together
    s_wr = wr_n; s_rd = rd_n;
    run_cmd(1, 1, 16'd2, 0, 8, 32'h0, a1, e, d, ad);
    chk("both_err", 32'(e), 1);
    chk("both_strobes", 32'((wr_n - s_wr) + (rd_n - s_rd)), 0);
    repeat (4) @(negedge clk_74a);
    chk("err_hold", 32'(dif.target_dataslot_err), 1);

    // Second read edge during PUSH is ignored
    s_wr = wr_n; s_done = done_total;
    dif.target_dataslot_id         = 16'd2;
    dif.target_dataslot_slotoffset = 0;
    dif.target_dataslot_length     = 8;
    dif.target_dataslot_bridgeaddr = 32'h5000_0000;
    @(negedge clk_74a); dif.target_dataslot_read = 1'b1;
    repeat (2) @(negedge clk_74a); dif.target_dataslot_read = 1'b0;
    repeat (4) @(negedge clk_74a); dif.target_dataslot_read = 1'b1;
    repeat (4) @(negedge clk_74a); dif.target_dataslot_read = 1'b0;
    repeat (60) @(negedge clk_74a);
    chk("reedge_done_cnt", 32'(done_total - s_done), 1);
    chk("reedge_wr_cnt", 32'(wr_n - s_wr), 2);
    chk("reedge_err", 32'(dif.target_dataslot_err), 0);

    // Reset while word 5 of a pull is outstanding
    rd_base = 8'hC0; rd_start = rd_n; s_rd = rd_n;
    dif.target_dataslot_length     = 83;
    dif.target_dataslot_bridgeaddr = 32'h3000_0000;
    @(negedge clk_74a); dif.target_dataslot_write = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_74a);
      if (i == 1) dif.target_dataslot_write = 1'b0;
      if (rd_n - s_rd >= 6) break;
    end
    chk("mid_rd_seen", 32'(rd_n - s_rd), 6);
    s_done = done_total;
    reset = 1'b1;
    #1;
    chk("mid_ack", 32'(dif.target_dataslot_ack), 0);
    chk("mid_addr", dif.bridge_addr, 0);
    chk("mid_strobes", {30'd0, dif.bridge_wr, dif.bridge_rd}, 0);
    repeat (3) @(negedge clk_74a);
    reset = 1'b0;
    repeat (3) @(negedge clk_74a);
    chk("mid_no_done", 32'(done_total - s_done), 0);

    // Fresh read shows the words pulled before the reset
    s_wr = wr_n;
    run_cmd(1, 0, 16'd2, 0, 20, 32'h4000_0000, a1, e, d, ad);
    chk("fresh_done", 32'(d), 1);
    chk("fresh_err", 32'(e), 0);
    chk("fresh_count", 32'(wr_n - s_wr), 5);
    chk("fresh_w0", wr_data[s_wr & 63], 32'hC0C0_C0C0);
    chk("fresh_w4", wr_data[(s_wr + 4) & 63], 32'hC4C4_C4C4);
    chk("fresh_w4_addr", wr_addr[(s_wr + 4) & 63], 32'h4000_0010);
    side_rd(12'd20, q);
    chk("mid_b20_kept", 32'(q), 32'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
